uart_rx_cfg: RTL

UART_RX_CFG -- requirements
Module: uart_rx_cfg

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_sync.sv | 24 ++
 rtl/uart_rx_cfg.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART parity mode constants and receiver state type
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK_WAIT
    } uart_state_t;

endpackage

// File: rtl/uart_sync.sv
// rtl/uart_sync.sv - two-flop synchronizer with configurable reset value
module uart_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic i_d,
    output logic o_q
);

    logic [1:0] r_ff;

    // Two-stage capture of the asynchronous input
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ff <= {2{RESET_VAL}};
        end else begin
            r_ff <= {r_ff[0], i_d};
        end
    end

    assign o_q = r_ff[1];

endmodule

// File: rtl/uart_rx_cfg.sv
// rtl/uart_rx_cfg.sv - configurable UART receiver with parity and stop-bit checking
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int             BW        = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0]  BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0]  BAUD_MID  = BW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [3:0]     BITS_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]     STOP_LAST = 4'(STOP_BITS - 1);
    localparam logic           PAR_ODD   = (PARITY == PARITY_ODD);

    generate
        if (CLKS_PER_BIT < 4 || CLKS_PER_BIT > 65535) begin : g_bad_cpb
            $error("uart_rx_cfg: CLKS_PER_BIT must be 4..65535");
        end
        if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_bits
            $error("uart_rx_cfg: DATA_BITS must be 5..9");
        end
        if (PARITY < 0 || PARITY > 2) begin : g_bad_par
            $error("uart_rx_cfg: PARITY must be 0, 1 or 2");
        end
        if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
            $error("uart_rx_cfg: STOP_BITS must be 1 or 2");
        end
    endgenerate

    uart_state_t            r_state;
    uart_state_t            w_next;
    logic [BW-1:0]          r_baud;
    logic [3:0]             r_bit_cnt;
    logic [DATA_BITS-1:0]   r_shift;
    logic                   r_par_lat;
    logic                   r_frm_lat;
    logic [DATA_BITS-1:0]   r_data;
    logic                   r_valid;
    logic                   r_par_err;
    logic                   r_frm_err;

    logic                   w_rx_s;
    logic                   w_tick;
    logic                   w_baud_clr;
    logic                   w_bit_clr;
    logic                   w_bit_inc;
    logic                   w_shift_en;
    logic                   w_par_smp;
    logic                   w_stop_smp;
    logic                   w_done;

    uart_sync #(.RESET_VAL(1'b1)) u_sync (
        .clk   (clk),
        .reset (reset),
        .i_d   (rx),
        .o_q   (w_rx_s)
    );

    assign w_tick = (r_baud == BAUD_LAST);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode and per-state sampling strobes
    always_comb begin
        w_next     = r_state;
        w_baud_clr = 1'b0;
        w_bit_clr  = 1'b0;
        w_bit_inc  = 1'b0;
        w_shift_en = 1'b0;
        w_par_smp  = 1'b0;
        w_stop_smp = 1'b0;
        w_done     = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_baud_clr = 1'b1;
                w_bit_clr  = 1'b1;
                if (!w_rx_s) begin
                    w_next = S_START;
                end
            end
            S_START: begin
                if (r_baud == BAUD_MID) begin
                    w_baud_clr = 1'b1;
                    w_next     = w_rx_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (w_tick) begin
                    w_shift_en = 1'b1;
                    if (r_bit_cnt == BITS_LAST) begin
                        w_bit_clr = 1'b1;
                        w_next    = (PARITY != PARITY_NONE) ? S_PARITY : S_STOP;
                    end else begin
                        w_bit_inc = 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (w_tick) begin
                    w_par_smp = 1'b1;
                    w_next    = S_STOP;
                end
            end
            S_STOP: begin
                if (w_tick) begin
                    w_stop_smp = 1'b1;
                    if (r_bit_cnt == STOP_LAST) begin
                        w_done    = 1'b1;
                        w_bit_clr = 1'b1;
                        // A line still low here is a break; wait it out without reframing
                        w_next    = w_rx_s ? S_IDLE : S_BREAK_WAIT;
                    end else begin
                        w_bit_inc = 1'b1;
                    end
                end
            end
            S_BREAK_WAIT: begin
                w_baud_clr = 1'b1;
                if (w_rx_s) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Baud and bit counters
    always_ff @(posedge clk) begin
        if (reset) begin
            r_baud    <= '0;
            r_bit_cnt <= '0;
        end else begin
            if (w_baud_clr || w_tick) begin
                r_baud <= '0;
            end else begin
                r_baud <= r_baud + BW'(1);
            end
            if (w_bit_clr) begin
                r_bit_cnt <= '0;
            end else if (w_bit_inc) begin
                r_bit_cnt <= r_bit_cnt + 4'd1;
            end
        end
    end

    // Shift register, error latches and the output registers loaded at frame end
    always_ff @(posedge clk) begin
        if (reset) begin
            r_shift   <= '0;
            r_par_lat <= 1'b0;
            r_frm_lat <= 1'b0;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_par_err <= 1'b0;
            r_frm_err <= 1'b0;
        end else begin
            r_valid <= w_done;
            if (r_state == S_IDLE) begin
                r_par_lat <= 1'b0;
                r_frm_lat <= 1'b0;
            end
            if (w_shift_en) begin
                r_shift <= {w_rx_s, r_shift[DATA_BITS-1:1]};
            end
            if (w_par_smp) begin
                r_par_lat <= ((^r_shift) ^ w_rx_s) != PAR_ODD;
            end
            if (w_stop_smp && !w_rx_s) begin
                r_frm_lat <= 1'b1;
            end
            if (w_done) begin
                r_data    <= r_shift;
                r_par_err <= r_par_lat;
                r_frm_err <= r_frm_lat | ~w_rx_s;
            end
        end
    end

    assign data       = r_data;
    assign valid      = r_valid;
    assign parity_err = r_par_err;
    assign frame_err  = r_frm_err;
    assign busy       = (r_state != S_IDLE);

endmodule
